oled_frame_streamer: RTL and testbench

//  Read side of the 1024-byte SSD1306 frame RAM (128 cols x 8 pages, 1 byte = 8 vertical px).
//  On start, sweeps addresses 0..1023 through the RAM's synchronous read port.

---
 rtl/oled_frame_streamer.sv | 145 ++++++++++++++
 tb/tb_oled_frame_streamer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oled_frame_streamer: sweeps the SSD1306 frame RAM and streams page-tagged   |
// | bytes to the I2C sender. Optional macro: OLED_STREAM_AUTOLOOP_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module oled_frame_streamer #(
    parameter int ADDR_W = 10,
    parameter int COL_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [7:0]        read_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_page_first,
    output logic [2:0]        tx_page,
    output logic              tx_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_tx_addr;
    logic              r_all_issued;
    logic              r_pend;
    logic [7:0]        r_buf [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;
    logic              r_busy;
    logic              r_done;

    logic              w_pop;
    logic              w_active;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_last_pop;

    assign w_pop      = (r_cnt != 2'd0) && tx_ready;
    assign w_active   = (r_state == S_FETCH) || (r_state == S_STREAM);
    assign w_occ      = {1'b0, r_cnt} + {2'b00, r_pend};
    // A read issued now lands next cycle; only issue if that byte is sure to fit.
    assign w_issue    = w_active && !r_all_issued && (w_occ <= (3'd1 + {2'b00, w_pop}));
    assign w_last_pop = w_pop && (r_tx_addr == c_last_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_tx_addr    <= '0;
            r_all_issued <= 1'b0;
            r_pend       <= 1'b0;
            r_buf[0]     <= 8'd0;
            r_buf[1]     <= 8'd0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_cnt        <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_tx_addr    <= '0;
            r_all_issued <= 1'b0;
            r_pend       <= 1'b0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_cnt        <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state      <= S_FETCH;
                        r_busy       <= 1'b1;
                        r_tx_addr    <= '0;
                        r_all_issued <= 1'b0;
                    end
                end
                S_FETCH: r_state <= S_STREAM;
                S_STREAM: begin
                    if (w_last_pop) begin
                        r_done <= 1'b1;
`ifndef OLED_STREAM_AUTOLOOP_EN
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
`endif
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            r_pend <= w_issue;
            if (w_issue) begin
                r_addr <= r_addr + 1'b1;
`ifndef OLED_STREAM_AUTOLOOP_EN
                if (r_addr == c_last_addr)
                    r_all_issued <= 1'b1;
`endif
            end

            if (r_pend) begin
                r_buf[r_wptr] <= read_data;
                r_wptr        <= ~r_wptr;
            end

            // Output address tracks the head byte; it wraps naturally in loop mode.
            if (w_pop) begin
                r_rptr    <= ~r_rptr;
                r_tx_addr <= r_tx_addr + 1'b1;
            end

            r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

    assign read_addr     = r_addr;
    assign tx_valid      = (r_cnt != 2'd0);
    assign tx_data       = r_buf[r_rptr];
    assign tx_page       = r_tx_addr[ADDR_W-1:COL_W];
    assign tx_page_first = tx_valid && (r_tx_addr[COL_W-1:0] == '0);
    assign tx_last       = tx_valid && (r_tx_addr == c_last_addr);
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_streamer.sv
`default_nettype none
// Scoreboard bench for oled_frame_streamer: a RAM model feeds the DUT and
// expected frames are queued from the frame layout rules.
module tb_oled_frame_streamer;

    localparam int ADDR_W = 10;
    localparam int COL_W  = 7;
    localparam int N      = 1 << ADDR_W;
    localparam int COLS   = 1 << COL_W;
`ifdef OLED_STREAM_AUTOLOOP_EN
    localparam bit AUTOLOOP = 1'b1;
`else
    localparam bit AUTOLOOP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              tx_ready = 1'b0;
    logic [ADDR_W-1:0] read_addr;
    logic [7:0]        read_data = 8'd0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_page_first;
    logic [2:0]        tx_page;
    logic              tx_last;
    logic              busy;
    logic              done;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] page;
        logic       first;
        logic       last;
    } item_t;

    item_t      sb_q[$];
    logic [7:0] mem [N];
    int         checks = 0;
    int         errors = 0;
    int         hs_count = 0;
    int         done_count = 0;
    bit         exp_done = 1'b0;
    int         ready_mode = 0;

    always #5 clk = ~clk;

    oled_frame_streamer #(.ADDR_W(ADDR_W), .COL_W(COL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .read_addr(read_addr), .read_data(read_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_page_first(tx_page_first), .tx_page(tx_page), .tx_last(tx_last),
        .busy(busy), .done(done)
    );

    // Synchronous-read frame RAM
    always @(posedge clk) read_data <= mem[read_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int a = 0; a < N; a++) begin
            item_t it;
            it.data  = mem[a];
            it.page  = 3'(a / COLS);
            it.first = ((a % COLS) == 0);
            it.last  = (a == N - 1);
            sb_q.push_back(it);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_abort();
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        sb_q.delete();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < budget);
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (hs_count < target) begin
            checks++; errors++;
            $display("FAIL hs_timeout: got %0d handshakes expected %0d", hs_count, target);
        end
    endtask

    // Queues the expected frame(s), runs one sweep to done; loop mode is then aborted.
    task automatic run_frame(input int budget);
        push_frame();
        if (AUTOLOOP) push_frame();
        pulse_start();
        wait_done(budget);
        if (AUTOLOOP) do_abort();
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            tx_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares presented bytes against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done = 1'b0;
            end else begin
                chk("done", 32'(done), 32'(exp_done));
                if (done) done_count++;
                if (exp_done) chk("busy_at_done", 32'(busy), 32'(AUTOLOOP));
                exp_done = 1'b0;
                if (tx_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte: got %0h expected no valid", tx_data);
                    end else begin
                        chk("tx_data", 32'(tx_data), 32'(sb_q[0].data));
                        chk("tx_page", 32'(tx_page), 32'(sb_q[0].page));
                        chk("tx_page_first", 32'(tx_page_first), 32'(sb_q[0].first));
                        chk("tx_last", 32'(tx_last), 32'(sb_q[0].last));
                        if (tx_ready) begin
                            exp_done = sb_q[0].last && !abort;
                            void'(sb_q.pop_front());
                            hs_count++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int dc0;
        foreach (mem[i]) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_read_addr", 32'(read_addr), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        @(negedge clk) rst_n = 1'b1;

        // Latency and full-rate frame
        ready_mode = 0;
        push_frame();
        if (AUTOLOOP) push_frame();
        pulse_start();
        @(negedge clk);
        chk("lat_busy_c1", 32'(busy), 1);
        chk("lat_valid_c1", 32'(tx_valid), 0);
        @(negedge clk);
        chk("lat_valid_c2", 32'(tx_valid), 0);
        @(negedge clk);
        chk("lat_valid_c3", 32'(tx_valid), 1);
        wait_done(N + 20);
        if (AUTOLOOP) do_abort();
        repeat (3) @(negedge clk);
        chk("idle_read_addr", 32'(read_addr), 0);

        // Random backpressure
        ready_mode = 1;
        run_frame(8 * N);

        // Abort at byte 500, then a fresh sweep
        ready_mode = 0;
        push_frame();
        pulse_start();
        wait_hs(hs_count + 500, 2 * N);
        do_abort();
        @(negedge clk);
        chk("abort_valid", 32'(tx_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (20) @(negedge clk);
        run_frame(N + 20);

        // Start while busy is ignored
        ready_mode = 1;
        push_frame();
        if (AUTOLOOP) push_frame();
        pulse_start();
        wait_hs(hs_count + 100, 2 * N);
        pulse_start();
        wait_done(8 * N);
        if (AUTOLOOP) do_abort();

        // Start and abort together in idle
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("sa_busy", 32'(busy), 0);
        chk("sa_valid", 32'(tx_valid), 0);

        // Asynchronous reset mid-frame
        ready_mode = 0;
        push_frame();
        pulse_start();
        wait_hs(hs_count + 300, 2 * N);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(tx_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_data", 32'(tx_data), 0);
        chk("mrst_addr", 32'(read_addr), 0);
        chk("mrst_tags", {29'd0, tx_page_first, tx_last, done}, 0);
        chk("mrst_page", 32'(tx_page), 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_frame(N + 20);

`ifdef OLED_STREAM_AUTOLOOP_EN
        // Continuous sweeps across frame boundaries
        ready_mode = 1;
        push_frame(); push_frame(); push_frame();
        dc0  = done_count;
        base = hs_count;
        pulse_start();
        wait_hs(base + 2 * N + 50, 16 * N);
        do_abort();
        chk("loop_done_pulses", 32'(done_count - dc0), 2);
        @(negedge clk);
        chk("loop_abort_busy", 32'(busy), 0);
`else
        dc0  = 0;
        base = 0;
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
